// File: rtl/main_mem_ctrl.sv
// Line-to-byte bridge for a byte-wide memory: one beat per clock, resp_valid Line_Bytes+1 cycles after accept.
// Backpressure: req_ready is high only in IDLE; requests are ignored while a line transfer or response is in flight.
module main_mem_ctrl #(
   parameter int Data_Width = 8,
   parameter int Addr_Width = 28,
   parameter int Line_Bytes = 4,
   parameter int Off_Bits   = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_we,
   input  logic [Addr_Width-1:0]            req_addr,
   input  logic [Line_Bytes*Data_Width-1:0] req_wdata,
   output logic                             resp_valid,
   output logic [Line_Bytes*Data_Width-1:0] resp_rdata,
   output logic                             mem_cs,
   output logic                             mem_oe,
   output logic                             mem_we,
   output logic [Addr_Width-1:0]            mem_addr,
   inout  wire  [Data_Width-1:0]            mem_data
);

   localparam int Line_Width = Line_Bytes * Data_Width;
   localparam int Hi_Width   = Addr_Width - Off_Bits;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                r_state, w_state_nxt;
   logic [Off_Bits-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [Hi_Width-1:0]   r_base_hi, w_base_hi_nxt;
   logic [Line_Width-1:0] r_wline, w_wline_nxt;
   logic [Line_Width-1:0] r_rline, w_rline_nxt;
   logic [Line_Width-1:0] r_resp_rdata, w_resp_rdata_nxt;
   logic                  r_req_ready, w_req_ready_nxt;
   logic                  r_resp_valid, w_resp_valid_nxt;
   logic                  r_mem_cs, w_mem_cs_nxt;
   logic                  r_mem_oe, w_mem_oe_nxt;
   logic                  r_mem_we, w_mem_we_nxt;
   logic [Addr_Width-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [Data_Width-1:0] r_dout, w_dout_nxt;
   logic [Data_Width-1:0] w_wbyte_inc;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_unused;

   // Line offset bits of the request address never reach the bus.
   assign w_unused  = ^req_addr[Off_Bits-1:0];
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_last    = &r_cnt;
   assign w_accept  = req_valid & r_req_ready;

   always_comb begin
      w_wbyte_inc = '0;
      for (int i = 0; i < Line_Bytes; i++) begin
         if (w_cnt_inc == Off_Bits'(i)) begin
            w_wbyte_inc = r_wline[i*Data_Width +: Data_Width];
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_base_hi_nxt    = r_base_hi;
      w_wline_nxt      = r_wline;
      w_rline_nxt      = r_rline;
      w_resp_rdata_nxt = r_resp_rdata;
      w_resp_valid_nxt = 1'b0;
      w_mem_cs_nxt     = 1'b0;
      w_mem_oe_nxt     = 1'b0;
      w_mem_we_nxt     = 1'b0;
      w_mem_addr_nxt   = r_mem_addr;
      w_dout_nxt       = r_dout;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_base_hi_nxt  = req_addr[Addr_Width-1:Off_Bits];
               w_wline_nxt    = req_wdata;
               w_cnt_nxt      = '0;
               w_mem_cs_nxt   = 1'b1;
               w_mem_addr_nxt = {req_addr[Addr_Width-1:Off_Bits], {Off_Bits{1'b0}}};
               if (req_we) begin
                  w_mem_we_nxt = 1'b1;
                  w_dout_nxt   = req_wdata[Data_Width-1:0];
                  w_state_nxt  = WRITE;
               end else begin
                  w_mem_oe_nxt = 1'b1;
                  w_state_nxt  = READ;
               end
            end
         end
         READ: begin
            for (int i = 0; i < Line_Bytes; i++) begin
               if (r_cnt == Off_Bits'(i)) begin
                  w_rline_nxt[i*Data_Width +: Data_Width] = mem_data;
               end
            end
            if (w_last) begin
               w_resp_rdata_nxt = w_rline_nxt;
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = RESP;
            end else begin
               w_cnt_nxt      = w_cnt_inc;
               w_mem_cs_nxt   = 1'b1;
               w_mem_oe_nxt   = 1'b1;
               w_mem_addr_nxt = {r_base_hi, w_cnt_inc};
            end
         end
         WRITE: begin
            if (w_last) begin
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = RESP;
            end else begin
               w_cnt_nxt      = w_cnt_inc;
               w_mem_cs_nxt   = 1'b1;
               w_mem_we_nxt   = 1'b1;
               w_mem_addr_nxt = {r_base_hi, w_cnt_inc};
               w_dout_nxt     = w_wbyte_inc;
            end
         end
         RESP: begin
            // Bus is idle for this cycle so a following read cannot collide with write data.
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      w_req_ready_nxt = (w_state_nxt == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_base_hi    <= '0;
         r_wline      <= '0;
         r_rline      <= '0;
         r_resp_rdata <= '0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_mem_cs     <= 1'b0;
         r_mem_oe     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_dout       <= '0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_base_hi    <= w_base_hi_nxt;
         r_wline      <= w_wline_nxt;
         r_rline      <= w_rline_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_mem_cs     <= w_mem_cs_nxt;
         r_mem_oe     <= w_mem_oe_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_dout       <= w_dout_nxt;
      end
   end

   assign mem_data   = (r_mem_cs & r_mem_we) ? r_dout : {Data_Width{1'bz}};
   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign mem_cs     = r_mem_cs;
   assign mem_oe     = r_mem_oe;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl with a byte-wide memory model on the bidirectional data bus.
module tb_main_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [27:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_cs;
   logic        mem_oe;
   logic        mem_we;
   logic [27:0] mem_addr;
   wire  [7:0]  mem_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulse = 0;
   int viol    = 0;

   logic [7:0] mem_arr [logic [27:0]];
   logic [7:0] r_q;

   main_mem_ctrl #(
      .Data_Width(8),
      .Addr_Width(28),
      .Line_Bytes(4),
      .Off_Bits(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .mem_cs(mem_cs),
      .mem_oe(mem_oe),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_data(mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [27:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : 8'h00;
   endfunction

   // Memory chip: read data appears after the falling edge, writes land on the rising edge.
   assign mem_data = (mem_cs && mem_oe && !mem_we) ? r_q : 8'bz;
   always @(negedge clk) if (mem_cs && mem_oe && !mem_we) r_q <= rd(mem_addr);
   always @(posedge clk) if (mem_cs && mem_we) mem_arr[mem_addr] = mem_data;

   always @(negedge clk) begin
      if (resp_valid) n_pulse++;
      if (mem_oe && mem_we) viol++;
      if (!mem_cs && (mem_oe || mem_we)) viol++;
      if (mem_cs && mem_we && $isunknown(mem_data)) viol++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_line(input logic we, input logic [27:0] addr, input logic [31:0] wd,
                          input logic [27:0] exp_base, input logic [31:0] exp_rd, input string tag);
      int p0;
      p0 = n_pulse;
      chk({tag, "_rdy_idle"}, req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      tick;
      req_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk({tag, "_addr"}, mem_addr, exp_base + 28'(b));
         chk({tag, "_ctl"}, {mem_cs, mem_oe, mem_we}, {1'b1, !we, we});
         chk({tag, "_rdy_busy"}, req_ready, 0);
         if (we) chk({tag, "_wbyte"}, mem_data, wd[8*b +: 8]);
         tick;
      end
      chk({tag, "_resp_vld"}, resp_valid, 1);
      chk({tag, "_turn_cs"}, mem_cs, 0);
      if (!we) chk({tag, "_rdata"}, resp_rdata, exp_rd);
      tick;
      chk({tag, "_resp_drop"}, resp_valid, 0);
      chk({tag, "_rdy_back"}, req_ready, 1);
      chk({tag, "_one_pulse"}, n_pulse - p0, 1);
   endtask

   initial begin
      int acc [3];
      int na;
      int rdy_cnt;
      int p0;
      logic rdy;

      rst_n     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem_arr[28'h40] = 8'h11;
      mem_arr[28'h41] = 8'h22;
      mem_arr[28'h42] = 8'h33;
      mem_arr[28'h43] = 8'h44;
      mem_arr[28'hFFFFFFC] = 8'h01;
      mem_arr[28'hFFFFFFD] = 8'h02;
      mem_arr[28'hFFFFFFE] = 8'h03;
      mem_arr[28'hFFFFFFF] = 8'h04;
      mem_arr[28'h0] = 8'hEE;
      mem_arr[28'h202] = 8'h77;
      mem_arr[28'h203] = 8'h88;
      #3 rst_n = 1'b0;
      tick;
      tick;
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_vld", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_ctl", {mem_cs, mem_oe, mem_we}, 3'b000);
      chk("rst_addr", mem_addr, 0);
      rst_n = 1'b1;
      chk("rst_ready_hold", req_ready, 0);
      tick;
      chk("rst_ready_rise", req_ready, 1);

      do_line(1'b0, 28'h40, 32'h0, 28'h40, 32'h44332211, "rd40");
      do_line(1'b1, 28'h100, 32'hDEADBEEF, 28'h100, 32'h0, "wr100");
      chk("wr100_m0", mem_arr[28'h100], 8'hEF);
      chk("wr100_m1", mem_arr[28'h101], 8'hBE);
      chk("wr100_m2", mem_arr[28'h102], 8'hAD);
      chk("wr100_m3", mem_arr[28'h103], 8'hDE);
      chk("wr_keeps_rdata", resp_rdata, 32'h44332211);
      do_line(1'b0, 28'h100, 32'h0, 28'h100, 32'hDEADBEEF, "rd100");
      do_line(1'b0, 28'h103, 32'h0, 28'h100, 32'hDEADBEEF, "rd103");
      do_line(1'b0, 28'hFFFFFFC, 32'h0, 28'hFFFFFFC, 32'h04030201, "rdtop");

      // Back-to-back: write, read, write with req_valid held high.
      p0        = n_pulse;
      na        = 0;
      rdy_cnt   = 0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 28'h300;
      req_wdata = 32'h01020304;
      for (int c = 0; c < 40 && na < 3; c++) begin
         rdy = req_ready;
         if (rdy) rdy_cnt++;
         tick;
         if (rdy) begin
            acc[na] = c;
            na++;
            if (na == 1) begin
               req_we   = 1'b0;
               req_addr = 28'h300;
            end else if (na == 2) begin
               req_we    = 1'b1;
               req_addr  = 28'h304;
               req_wdata = 32'h55667788;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", na, 3);
      chk("b2b_gap1", acc[1] - acc[0], 6);
      chk("b2b_gap2", acc[2] - acc[1], 6);
      chk("b2b_rdy_cycles", rdy_cnt, 3);
      for (int k = 0; k < 6; k++) tick;
      chk("b2b_pulses", n_pulse - p0, 3);
      chk("b2b_rdata", resp_rdata, 32'h01020304);
      chk("b2b_m300", mem_arr[28'h300], 8'h04);
      chk("b2b_m304", mem_arr[28'h304], 8'h88);
      chk("b2b_m307", mem_arr[28'h307], 8'h55);
      chk("b2b_ready", req_ready, 1);

      // Reset in the middle of a write, with beat 2 on the bus.
      p0        = n_pulse;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 28'h200;
      req_wdata = 32'hA1B2C3D4;
      tick;
      req_valid = 1'b0;
      tick;
      tick;
      chk("rw_beat2_addr", mem_addr, 28'h202);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_async_cs", mem_cs, 0);
      chk("rw_async_we", mem_we, 0);
      chk("rw_async_addr", mem_addr, 0);
      tick;
      tick;
      rst_n = 1'b1;
      chk("rw_rdy_hold", req_ready, 0);
      tick;
      chk("rw_rdy_rise", req_ready, 1);
      chk("rw_no_pulse", n_pulse - p0, 0);
      chk("rw_m200", mem_arr[28'h200], 8'hD4);
      chk("rw_m201", mem_arr[28'h201], 8'hC3);
      chk("rw_m202", mem_arr[28'h202], 8'h77);
      chk("rw_m203", mem_arr[28'h203], 8'h88);

      // Reset in the middle of a read after three captured beats.
      do_line(1'b0, 28'h100, 32'h0, 28'h100, 32'hDEADBEEF, "rdpre");
      p0        = n_pulse;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 28'h40;
      tick;
      req_valid = 1'b0;
      tick;
      tick;
      tick;
      #2 rst_n = 1'b0;
      #1;
      chk("rr_rdata_clr", resp_rdata, 0);
      chk("rr_resp_vld", resp_valid, 0);
      chk("rr_async_cs", mem_cs, 0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("rr_rdy_rise", req_ready, 1);
      chk("rr_no_pulse", n_pulse - p0, 0);
      do_line(1'b0, 28'h40, 32'h0, 28'h40, 32'h44332211, "rdpost");

      chk("bus_invariants", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
